// File: rtl/battle_turn_controller.sv
`default_nettype none
// ============================================================================
// Module   : battle_turn_controller
// Brief    : Debounces the score key, validates each shot, strobes the shot
//            checker once per accepted press and latches results, bomb, hit
//            and shot counters. Optional macro SHOT_LIMIT_EN adds a shot cap.
// Revision : 1.0 - initial release
// ============================================================================
module battle_turn_controller #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int BIG_BOMBS       = 2,
  parameter int SHIP_CELLS      = 19,
  parameter int MAX_SHOTS       = 40
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       score_key_n,
  input  logic [3:0] x,
  input  logic [3:0] y,
  input  logic       big_req,
  input  logic       chk_hit,
  input  logic       chk_near_miss,
  input  logic       chk_miss,
  input  logic [4:0] chk_biggest,
  input  logic [3:0] chk_num_hit,
  output logic       score_this,
  output logic [3:0] shot_x,
  output logic [3:0] shot_y,
  output logic       shot_big,
  output logic       something_wrong,
  output logic       hit,
  output logic       near_miss,
  output logic       miss,
  output logic [4:0] biggest_ship,
  output logic [3:0] num_hit,
  output logic [1:0] big_left,
  output logic [4:0] total_hits,
  output logic [6:0] shots_taken,
  output logic       game_over
);

  localparam int              CNT_W       = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] DB_LAST     = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [1:0]      BIG_INIT    = 2'(BIG_BOMBS);
  localparam logic [4:0]      SHIP_TARGET = 5'(SHIP_CELLS);
  localparam logic [6:0]      SHOT_CAP    = 7'(MAX_SHOTS);

`ifdef SHOT_LIMIT_EN
  localparam bit SHOT_LIMIT_ON = 1'b1;
`else
  localparam bit SHOT_LIMIT_ON = 1'b0;
`endif

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CHECK = 3'd1,
    ST_SCORE = 3'd2,
    ST_HOLD  = 3'd3,
    ST_OVER  = 3'd4
  } state_t;

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic             db_level_q, db_level_d;
  logic [CNT_W-1:0] db_cnt_q, db_cnt_d;
  logic             press_q, press_d;
  state_t           state_q, state_d;
  logic             score_this_q, score_this_d;
  logic [3:0]       shot_x_q, shot_x_d;
  logic [3:0]       shot_y_q, shot_y_d;
  logic             shot_big_q, shot_big_d;
  logic             something_wrong_q, something_wrong_d;
  logic             hit_q, hit_d;
  logic             near_miss_q, near_miss_d;
  logic             miss_q, miss_d;
  logic [4:0]       biggest_q, biggest_d;
  logic [3:0]       num_hit_q, num_hit_d;
  logic [1:0]       big_left_q, big_left_d;
  logic [4:0]       total_hits_q, total_hits_d;
  logic [6:0]       shots_taken_q, shots_taken_d;
  logic             game_over_q, game_over_d;

  logic       coord_ok;
  logic       bomb_ok;
  logic [5:0] hits_sum;
  logic       end_by_hits;
  logic       end_by_shots;

  always_comb begin
    coord_ok     = (shot_x_q >= 4'd1) && (shot_x_q <= 4'd10) &&
                   (shot_y_q >= 4'd1) && (shot_y_q <= 4'd10);
    bomb_ok      = !(shot_big_q && (big_left_q == 2'd0));
    hits_sum     = {1'b0, total_hits_q} + {2'b00, chk_num_hit};
    end_by_hits  = (total_hits_q >= SHIP_TARGET);
    end_by_shots = SHOT_LIMIT_ON && (shots_taken_q == SHOT_CAP);
  end

  // Key chain: synchronizer, then a counter that only advances while the
  // synchronized key disagrees with the accepted level.
  always_comb begin
    sync1_d    = score_key_n;
    sync2_d    = sync1_q;
    db_level_d = db_level_q;
    db_cnt_d   = db_cnt_q;
    press_d    = 1'b0;
    if (sync2_q == db_level_q) begin
      db_cnt_d = '0;
    end else if (db_cnt_q == DB_LAST) begin
      db_level_d = sync2_q;
      db_cnt_d   = '0;
      press_d    = ~sync2_q;
    end else begin
      db_cnt_d = db_cnt_q + 1'b1;
    end
  end

  always_comb begin
    state_d           = state_q;
    score_this_d      = 1'b0;
    shot_x_d          = shot_x_q;
    shot_y_d          = shot_y_q;
    shot_big_d        = shot_big_q;
    something_wrong_d = something_wrong_q;
    hit_d             = hit_q;
    near_miss_d       = near_miss_q;
    miss_d            = miss_q;
    biggest_d         = biggest_q;
    num_hit_d         = num_hit_q;
    big_left_d        = big_left_q;
    total_hits_d      = total_hits_q;
    shots_taken_d     = shots_taken_q;
    game_over_d       = game_over_q;

    case (state_q)
      ST_IDLE: begin
        if (press_q) begin
          shot_x_d   = x;
          shot_y_d   = y;
          shot_big_d = big_req;
          state_d    = ST_CHECK;
        end
      end
      ST_CHECK: begin
        if (coord_ok && bomb_ok) begin
          something_wrong_d = 1'b0;
          score_this_d      = 1'b1;
          state_d           = ST_SCORE;
        end else begin
          something_wrong_d = 1'b1;
          state_d           = ST_HOLD;
        end
      end
      ST_SCORE: begin
        hit_d         = chk_hit;
        near_miss_d   = chk_near_miss;
        miss_d        = chk_miss;
        biggest_d     = chk_biggest;
        num_hit_d     = chk_num_hit;
        total_hits_d  = hits_sum[5] ? 5'd31 : hits_sum[4:0];
        shots_taken_d = (shots_taken_q == 7'd127) ? shots_taken_q : shots_taken_q + 7'd1;
        if (shot_big_q) begin
          big_left_d = big_left_q - 2'd1;
        end
        state_d = ST_HOLD;
      end
      ST_HOLD: begin
        // A held key must be released before the next shot can be armed.
        if (db_level_q) begin
          if (end_by_hits || end_by_shots) begin
            game_over_d = 1'b1;
            state_d     = ST_OVER;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_OVER: begin
        state_d = ST_OVER;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      sync1_q           <= 1'b1;
      sync2_q           <= 1'b1;
      db_level_q        <= 1'b1;
      db_cnt_q          <= '0;
      press_q           <= 1'b0;
      state_q           <= ST_IDLE;
      score_this_q      <= 1'b0;
      shot_x_q          <= 4'd0;
      shot_y_q          <= 4'd0;
      shot_big_q        <= 1'b0;
      something_wrong_q <= 1'b0;
      hit_q             <= 1'b0;
      near_miss_q       <= 1'b0;
      miss_q            <= 1'b0;
      biggest_q         <= 5'd0;
      num_hit_q         <= 4'd0;
      big_left_q        <= BIG_INIT;
      total_hits_q      <= 5'd0;
      shots_taken_q     <= 7'd0;
      game_over_q       <= 1'b0;
    end else begin
      sync1_q           <= sync1_d;
      sync2_q           <= sync2_d;
      db_level_q        <= db_level_d;
      db_cnt_q          <= db_cnt_d;
      press_q           <= press_d;
      state_q           <= state_d;
      score_this_q      <= score_this_d;
      shot_x_q          <= shot_x_d;
      shot_y_q          <= shot_y_d;
      shot_big_q        <= shot_big_d;
      something_wrong_q <= something_wrong_d;
      hit_q             <= hit_d;
      near_miss_q       <= near_miss_d;
      miss_q            <= miss_d;
      biggest_q         <= biggest_d;
      num_hit_q         <= num_hit_d;
      big_left_q        <= big_left_d;
      total_hits_q      <= total_hits_d;
      shots_taken_q     <= shots_taken_d;
      game_over_q       <= game_over_d;
    end
  end

  assign score_this      = score_this_q;
  assign shot_x          = shot_x_q;
  assign shot_y          = shot_y_q;
  assign shot_big        = shot_big_q;
  assign something_wrong = something_wrong_q;
  assign hit             = hit_q;
  assign near_miss       = near_miss_q;
  assign miss            = miss_q;
  assign biggest_ship    = biggest_q;
  assign num_hit         = num_hit_q;
  assign big_left        = big_left_q;
  assign total_hits      = total_hits_q;
  assign shots_taken     = shots_taken_q;
  assign game_over       = game_over_q;

endmodule
`default_nettype wire

// File: tb/tb_battle_turn_controller.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_battle_turn_controller
// Brief    : Directed bench for battle_turn_controller with fast debounce.
// Revision : 1.0 - initial release
// ============================================================================
module tb_battle_turn_controller;

  localparam int TB_MAX_SHOTS = 7;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       score_key_n = 1'b1;
  logic [3:0] x = 4'd0;
  logic [3:0] y = 4'd0;
  logic       big_req = 1'b0;
  logic       chk_hit = 1'b0;
  logic       chk_near_miss = 1'b0;
  logic       chk_miss = 1'b0;
  logic [4:0] chk_biggest = 5'd0;
  logic [3:0] chk_num_hit = 4'd0;

  logic       score_this;
  logic [3:0] shot_x;
  logic [3:0] shot_y;
  logic       shot_big;
  logic       something_wrong;
  logic       hit;
  logic       near_miss;
  logic       miss;
  logic [4:0] biggest_ship;
  logic [3:0] num_hit;
  logic [1:0] big_left;
  logic [4:0] total_hits;
  logic [6:0] shots_taken;
  logic       game_over;

  int n_checks = 0;
  int n_fails  = 0;
  int pulses   = 0;
  bit prev_strobe   = 1'b0;
  bit double_strobe = 1'b0;
  int p0;

  battle_turn_controller #(
    .DEBOUNCE_CYCLES(4),
    .BIG_BOMBS      (2),
    .SHIP_CELLS     (19),
    .MAX_SHOTS      (TB_MAX_SHOTS)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .score_key_n    (score_key_n),
    .x              (x),
    .y              (y),
    .big_req        (big_req),
    .chk_hit        (chk_hit),
    .chk_near_miss  (chk_near_miss),
    .chk_miss       (chk_miss),
    .chk_biggest    (chk_biggest),
    .chk_num_hit    (chk_num_hit),
    .score_this     (score_this),
    .shot_x         (shot_x),
    .shot_y         (shot_y),
    .shot_big       (shot_big),
    .something_wrong(something_wrong),
    .hit            (hit),
    .near_miss      (near_miss),
    .miss           (miss),
    .biggest_ship   (biggest_ship),
    .num_hit        (num_hit),
    .big_left       (big_left),
    .total_hits     (total_hits),
    .shots_taken    (shots_taken),
    .game_over      (game_over)
  );

  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (score_this === 1'b1) begin
      pulses = pulses + 1;
      if (prev_strobe) double_strobe = 1'b1;
    end
    prev_strobe = (score_this === 1'b1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_shot(input logic [3:0] px, input logic [3:0] py, input logic pb,
                          input logic ph, input logic pn, input logic pm,
                          input logic [4:0] pbig, input logic [3:0] pnum);
    x = px; y = py; big_req = pb;
    chk_hit = ph; chk_near_miss = pn; chk_miss = pm;
    chk_biggest = pbig; chk_num_hit = pnum;
  endtask

  // Hold the key low for hold_cycles, release, and allow the release to settle.
  task automatic press(input int hold_cycles);
    score_key_n = 1'b0;
    repeat (hold_cycles) @(negedge clock);
    score_key_n = 1'b1;
    repeat (10) @(negedge clock);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    check("rst_big_left", big_left, 2);
    check("rst_total_hits", total_hits, 0);
    check("rst_shots_taken", shots_taken, 0);
    check("rst_game_over", game_over, 0);
    check("rst_score_this", score_this, 0);
    check("rst_something_wrong", something_wrong, 0);

    set_shot(4'd3, 4'd2, 1'b0, 1'b1, 1'b0, 1'b0, 5'b01000, 4'd1);
    p0 = pulses; press(2);
    check("bounce_no_strobe", pulses - p0, 0);
    check("bounce_shots", shots_taken, 0);

    p0 = pulses; press(8);
    check("hit_one_strobe", pulses - p0, 1);
    check("hit_flag", hit, 1);
    check("hit_biggest", biggest_ship, 5'b01000);
    check("hit_num_hit", num_hit, 1);
    check("hit_total", total_hits, 1);
    check("hit_shots", shots_taken, 1);
    check("hit_big_left", big_left, 2);
    check("hit_wrong", something_wrong, 0);
    check("hit_shot_x", shot_x, 3);
    check("hit_shot_y", shot_y, 2);

    set_shot(4'd0, 4'd5, 1'b0, 1'b0, 1'b0, 1'b1, 5'd0, 4'd0);
    p0 = pulses; press(8);
    check("x0_no_strobe", pulses - p0, 0);
    check("x0_wrong", something_wrong, 1);
    check("x0_shots", shots_taken, 1);
    check("x0_total", total_hits, 1);
    check("x0_hit_held", hit, 1);

    set_shot(4'd11, 4'd1, 1'b0, 1'b0, 1'b0, 1'b1, 5'd0, 4'd0);
    p0 = pulses; press(8);
    check("x11_no_strobe", pulses - p0, 0);
    check("x11_wrong", something_wrong, 1);

    set_shot(4'd10, 4'd10, 1'b0, 1'b0, 1'b0, 1'b1, 5'd0, 4'd0);
    p0 = pulses; press(8);
    check("corner_strobe", pulses - p0, 1);
    check("corner_wrong", something_wrong, 0);
    check("corner_miss", miss, 1);
    check("corner_hit", hit, 0);
    check("corner_shots", shots_taken, 2);
    check("corner_total", total_hits, 1);

    set_shot(4'd5, 4'd5, 1'b1, 1'b1, 1'b0, 1'b0, 5'b00100, 4'd3);
    press(8);
    check("big1_left", big_left, 1);
    check("big1_total", total_hits, 4);
    check("big1_shots", shots_taken, 3);

    set_shot(4'd6, 4'd6, 1'b1, 1'b1, 1'b0, 1'b0, 5'b00010, 4'd2);
    press(8);
    check("big2_left", big_left, 0);
    check("big2_total", total_hits, 6);
    check("big2_shots", shots_taken, 4);

    set_shot(4'd7, 4'd7, 1'b1, 1'b1, 1'b0, 1'b0, 5'b00010, 4'd2);
    p0 = pulses; press(8);
    check("big3_no_strobe", pulses - p0, 0);
    check("big3_wrong", something_wrong, 1);
    check("big3_left", big_left, 0);
    check("big3_shots", shots_taken, 4);

    set_shot(4'd1, 4'd1, 1'b0, 1'b1, 1'b0, 1'b0, 5'b10000, 4'd9);
    press(8);
    check("nine_total", total_hits, 15);
    check("nine_shots", shots_taken, 5);
    check("nine_wrong", something_wrong, 0);
    check("nine_not_over", game_over, 0);

    // Winning shot: game_over follows the debounced release by one cycle.
    set_shot(4'd2, 4'd2, 1'b0, 1'b1, 1'b0, 1'b0, 5'b00001, 4'd4);
    score_key_n = 1'b0;
    repeat (8) @(negedge clock);
    score_key_n = 1'b1;
    repeat (6) @(negedge clock);
    check("win_before_release", game_over, 0);
    @(negedge clock);
    check("win_game_over", game_over, 1);
    check("win_total", total_hits, 19);
    check("win_shots", shots_taken, 6);

    set_shot(4'd4, 4'd4, 1'b0, 1'b1, 1'b0, 1'b0, 5'b00001, 4'd5);
    p0 = pulses; press(8);
    check("over_no_strobe", pulses - p0, 0);
    check("over_shots", shots_taken, 6);
    check("over_total", total_hits, 19);
    check("over_held", game_over, 1);
    check("over_shot_x", shot_x, 2);

    reset = 1'b1;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    check("rst2_big_left", big_left, 2);
    check("rst2_game_over", game_over, 0);
    check("rst2_total", total_hits, 0);

    // Reset lands while the shot is in CHECK, before the strobe edge.
    set_shot(4'd3, 4'd3, 1'b0, 1'b1, 1'b0, 1'b0, 5'b01000, 4'd1);
    p0 = pulses;
    score_key_n = 1'b0;
    repeat (7) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    check("abort_score_this", score_this, 0);
    score_key_n = 1'b1;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    repeat (10) @(negedge clock);
    check("abort_no_strobe", pulses - p0, 0);
    check("abort_shots", shots_taken, 0);
    check("abort_total", total_hits, 0);

`ifdef SHOT_LIMIT_EN
    set_shot(4'd8, 4'd8, 1'b0, 1'b0, 1'b0, 1'b1, 5'd0, 4'd0);
    for (int i = 0; i < TB_MAX_SHOTS - 1; i++) press(8);
    check("limit_not_yet", game_over, 0);
    press(8);
    check("limit_shots", shots_taken, TB_MAX_SHOTS);
    check("limit_game_over", game_over, 1);
`endif

    check("single_cycle_strobe", double_strobe, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
`default_nettype wire
